// File: rtl/rf_write_sched.sv
// rtl/rf_write_sched.sv - regfile write-port scheduler: writeback vs long-latency result queue
// Shares one regfile write port; queued results get priority only when writeback is idle or starved too long.
module rf_write_sched #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_wr_enable,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0]     wb_wr_data,
  output logic                  wb_stall,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  lu_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic                  rf_wr_enable,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data
);

  localparam int NREGS = 1 << REG_ADDR_W;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);
  localparam logic [SW-1:0] S_LAST = SW'(STARVE_MAX - 1);

  logic [REG_ADDR_W-1:0] q_rd   [QDEPTH];
  logic [DATA_W-1:0]     q_data [QDEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         q_count;
  logic                  q_empty;
  logic                  push;
  logic                  pop;
  logic                  grant_q;
  logic                  grant_wb;
  logic                  src_lu;
  logic [SW-1:0]         starve_cnt;
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_set;
  logic [NREGS-1:0]      busy_clr;

  assign q_empty  = (q_count == '0);
  assign lu_ready = (q_count != Q_FULL);
  assign push     = lu_valid && lu_ready;
  // A stall cycle forces the queue through even if writeback is asserting.
  assign grant_q  = !q_empty && (wb_stall || !wb_wr_enable);
  assign grant_wb = !grant_q && wb_wr_enable;
  assign pop      = grant_q;

  assign issue_ready = !busy[issue_rd];
  assign rs1_busy    = (rs1_addr != '0) && busy[rs1_addr];
  assign rs2_busy    = (rs2_addr != '0) && busy[rs2_addr];
  assign rd_busy     = (rd_addr  != '0) && busy[rd_addr];

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_valid && issue_ready && (issue_rd != '0)) busy_set[issue_rd] = 1'b1;
    if (rf_wr_enable && src_lu) busy_clr[rf_wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd;
      q_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // rd = 0 entries are still popped; only the write enable is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_enable <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      src_lu       <= 1'b0;
    end else if (grant_q) begin
      rf_wr_enable <= (q_rd[rd_ptr] != '0);
      rf_wr_addr   <= q_rd[rd_ptr];
      rf_wr_data   <= q_data[rd_ptr];
      src_lu       <= 1'b1;
    end else if (grant_wb) begin
      rf_wr_enable <= (wb_wr_addr != '0);
      rf_wr_addr   <= wb_wr_addr;
      rf_wr_data   <= wb_wr_data;
      src_lu       <= 1'b0;
    end else begin
      rf_wr_enable <= 1'b0;
      src_lu       <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (!q_empty && grant_wb) begin
        if (starve_cnt == S_LAST) begin
          wb_stall   <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// tb/tb_rf_write_sched.sv - directed and randomized checks of rf_write_sched against a queue-based model
module tb_rf_write_sched;

  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 4;
  localparam int NREGS      = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } rec_t;

  logic          clk;
  logic          reset;
  logic          wb_wr_enable;
  logic [AW-1:0] wb_wr_addr;
  logic [DW-1:0] wb_wr_data;
  logic          wb_stall;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [AW-1:0] rd_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          rd_busy;
  logic          rf_wr_enable;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  rf_write_sched #(
    .REG_ADDR_W(AW),
    .DATA_W    (DW),
    .QDEPTH    (QDEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_wr_enable(wb_wr_enable),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .wb_stall    (wb_stall),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .rf_wr_enable(rf_wr_enable),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_checks;

  // Reference state: result queue, busy set, starvation count, last regfile write.
  rec_t             mq[$];
  logic [NREGS-1:0] mbusy;
  int               m_cnt;
  logic             m_stall;
  logic             m_en;
  logic             m_src;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  bit               last_push;
  rec_t             seen[$];
  rec_t             exp_order[3];

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    wb_wr_enable = 1'b0;
    wb_wr_addr   = '0;
    wb_wr_data   = '0;
    lu_valid     = 1'b0;
    lu_rd        = '0;
    lu_data      = '0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
    rd_addr      = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy   = '0;
    m_cnt   = 0;
    m_stall = 1'b0;
    m_en    = 1'b0;
    m_src   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock: check lookups against the model, advance the model, then check registered outputs.
  task automatic tick();
    logic             gq;
    logic             gw;
    logic             n_en;
    logic             n_src;
    logic             n_stall;
    logic [AW-1:0]    n_addr;
    logic [DW-1:0]    n_data;
    logic [NREGS-1:0] n_busy;
    int               qn;
    rec_t             r;
    #1;
    qn = mq.size();
    check_b("lu_ready", lu_ready, qn < QDEPTH);
    check_b("issue_ready", issue_ready, !mbusy[issue_rd]);
    check_b("rs1_busy", rs1_busy, (rs1_addr != 0) && mbusy[rs1_addr]);
    check_b("rs2_busy", rs2_busy, (rs2_addr != 0) && mbusy[rs2_addr]);
    check_b("rd_busy", rd_busy, (rd_addr != 0) && mbusy[rd_addr]);
    gq = 1'b0;
    gw = 1'b0;
    if (m_stall && qn > 0) gq = 1'b1;
    else if (wb_wr_enable) gw = 1'b1;
    else if (qn > 0) gq = 1'b1;
    n_busy = mbusy;
    if (m_en && m_src) n_busy[m_addr] = 1'b0;
    if (issue_valid && !mbusy[issue_rd] && issue_rd != 0) n_busy[issue_rd] = 1'b1;
    if (qn > 0 && gw) m_cnt++;
    else m_cnt = 0;
    n_stall = (m_cnt == STARVE_MAX);
    if (n_stall) m_cnt = 0;
    n_addr = m_addr;
    n_data = m_data;
    n_en   = 1'b0;
    n_src  = 1'b0;
    if (gq) begin
      r      = mq.pop_front();
      n_en   = (r.rd != 0);
      n_addr = r.rd;
      n_data = r.data;
      n_src  = 1'b1;
    end else if (gw) begin
      n_en   = (wb_wr_addr != 0);
      n_addr = wb_wr_addr;
      n_data = wb_wr_data;
    end
    last_push = lu_valid && (qn < QDEPTH);
    if (last_push) begin
      r.rd   = lu_rd;
      r.data = lu_data;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    mbusy   = n_busy;
    m_stall = n_stall;
    m_en    = n_en;
    m_src   = n_src;
    m_addr  = n_addr;
    m_data  = n_data;
    check_b("wb_stall", wb_stall, m_stall);
    check_b("rf_wr_enable", rf_wr_enable, m_en);
    if (m_en) begin
      check_w("rf_wr_addr", 32'(rf_wr_addr), 32'(m_addr));
      check_w("rf_wr_data", rf_wr_data, m_data);
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    reset    = 1'b1;
    idle();
    model_reset();

    @(posedge clk);
    #1;
    check_b("rst_wb_stall", wb_stall, 1'b0);
    check_b("rst_rf_wr_enable", rf_wr_enable, 1'b0);
    check_w("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    check_w("rst_rf_wr_data", rf_wr_data, 32'd0);
    check_b("rst_lu_ready", lu_ready, 1'b1);
    check_b("rst_issue_ready", issue_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Writeback only, then a write to x0.
    wb_wr_enable = 1'b1;
    wb_wr_addr   = 5'd5;
    wb_wr_data   = 32'hDEAD_BEEF;
    tick();
    check_b("wb_en", rf_wr_enable, 1'b1);
    check_w("wb_addr", 32'(rf_wr_addr), 32'd5);
    check_w("wb_data", rf_wr_data, 32'hDEAD_BEEF);
    wb_wr_addr = 5'd0;
    tick();
    check_b("wb_x0_no_write", rf_wr_enable, 1'b0);
    idle();
    tick();

    // Scoreboard round trip on r7.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    rs1_addr    = 5'd7;
    #1 check_b("sb_rs1_busy_set", rs1_busy, 1'b1);
    issue_valid = 1'b1;
    #1 check_b("sb_issue_blocked", issue_ready, 1'b0);
    issue_valid = 1'b0;
    lu_valid    = 1'b1;
    lu_rd       = 5'd7;
    lu_data     = 32'h42;
    tick();
    lu_valid = 1'b0;
    tick();
    check_b("sb_wr_en", rf_wr_enable, 1'b1);
    check_w("sb_wr_addr", 32'(rf_wr_addr), 32'd7);
    check_w("sb_wr_data", rf_wr_data, 32'h42);
    check_b("sb_busy_until_commit", rs1_busy, 1'b1);
    tick();
    check_b("sb_busy_cleared", rs1_busy, 1'b0);

    // Full queue while writeback hogs the port; third result waits.
    idle();
    seen.delete();
    exp_order[0] = {5'd9,  32'hA0A0_0009};
    exp_order[1] = {5'd10, 32'hB0B0_000A};
    exp_order[2] = {5'd11, 32'hC0C0_000B};
    wb_wr_enable = 1'b1;
    wb_wr_addr   = 5'd3;
    wb_wr_data   = 32'h1111_0000;
    lu_valid     = 1'b1;
    lu_rd        = exp_order[0].rd;
    lu_data      = exp_order[0].data;
    tick();
    lu_rd   = exp_order[1].rd;
    lu_data = exp_order[1].data;
    tick();
    check_b("full_lu_ready_low", lu_ready, 1'b0);
    lu_rd   = exp_order[2].rd;
    lu_data = exp_order[2].data;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) wb_wr_enable = 1'b0;
      wb_wr_data = 32'h1111_0000 + i;
      tick();
      if (last_push && lu_rd == exp_order[2].rd) lu_valid = 1'b0;
      if (rf_wr_enable && rf_wr_addr != 5'd3) seen.push_back({rf_wr_addr, rf_wr_data});
    end
    check_w("full_drained_count", 32'(seen.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < seen.size()) begin
        check_w("full_order_addr", 32'(seen[k].rd), 32'(exp_order[k].rd));
        check_w("full_order_data", seen[k].data, exp_order[k].data);
      end
    end

    // Starvation: one queued entry against continuous writeback.
    idle();
    tick();
    wb_wr_enable = 1'b1;
    wb_wr_addr   = 5'd4;
    wb_wr_data   = 32'h5000_0000;
    lu_valid     = 1'b1;
    lu_rd        = 5'd12;
    lu_data      = 32'hD00D_000C;
    tick();
    lu_valid = 1'b0;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      wb_wr_data = 32'h5000_0000 + i;
      tick();
      check_w("starve_wb_write", rf_wr_data, 32'h5000_0000 + i);
      check_b("starve_stall_timing", wb_stall, i == STARVE_MAX);
    end
    wb_wr_data = 32'h5000_00FF;
    tick();
    check_b("starve_q_en", rf_wr_enable, 1'b1);
    check_w("starve_q_addr", 32'(rf_wr_addr), 32'd12);
    check_w("starve_q_data", rf_wr_data, 32'hD00D_000C);
    check_b("starve_stall_one_cycle", wb_stall, 1'b0);
    tick();
    check_w("starve_wb_held_addr", 32'(rf_wr_addr), 32'd4);
    check_w("starve_wb_held_data", rf_wr_data, 32'h5000_00FF);

    // Asynchronous reset with two queued entries and busy bits set.
    idle();
    tick();
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    tick();
    issue_rd = 5'd5;
    tick();
    issue_valid  = 1'b0;
    wb_wr_enable = 1'b1;
    wb_wr_addr   = 5'd20;
    wb_wr_data   = 32'h7777_0000;
    lu_valid     = 1'b1;
    lu_rd        = 5'd3;
    lu_data      = 32'h3333_3333;
    tick();
    lu_rd   = 5'd5;
    lu_data = 32'h5555_5555;
    tick();
    lu_valid = 1'b0;
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    rd_addr  = 5'd5;
    issue_rd = 5'd5;
    #1 check_b("pre_rst_rs1_busy", rs1_busy, 1'b1);
    check_b("pre_rst_lu_full", lu_ready, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_b("arst_rf_wr_enable", rf_wr_enable, 1'b0);
    check_w("arst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    check_w("arst_rf_wr_data", rf_wr_data, 32'd0);
    check_b("arst_wb_stall", wb_stall, 1'b0);
    check_b("arst_lu_ready", lu_ready, 1'b1);
    check_b("arst_rs1_busy", rs1_busy, 1'b0);
    check_b("arst_rs2_busy", rs2_busy, 1'b0);
    check_b("arst_rd_busy", rd_busy, 1'b0);
    check_b("arst_issue_ready", issue_ready, 1'b1);
    reset = 1'b0;
    model_reset();
    idle();
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wb_wr_enable = ($urandom_range(0, 9) < 6);
      wb_wr_addr   = 5'($urandom_range(0, 31));
      wb_wr_data   = $urandom;
      lu_valid     = ($urandom_range(0, 9) < 4);
      lu_rd        = 5'($urandom_range(0, 7));
      lu_data      = $urandom;
      issue_valid  = ($urandom_range(0, 9) < 3);
      issue_rd     = 5'($urandom_range(0, 7));
      rs1_addr     = 5'($urandom_range(0, 7));
      rs2_addr     = 5'($urandom_range(0, 7));
      rd_addr      = 5'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
